rs_frame_checker: RTL and testbench

Receive-side counterpart of the RS encoder. Accepts framed N-symbol codewords on the same start/end/valid/ready handshake the encoder drives, computes the N-K syndromes over GF(2^WORD_LENGTH), and buffers the K message symbols. Once the frame is complete, it replays those K symbols downstream with a per-frame corruption flag. It sits between the channel interface and a later full decoder, and can also run standalone as an error detector.

---
 rtl/rs_pkg.sv | 44 ++++
 rtl/rs_syndrome_calc.sv | 34 +++
 rtl/rs_frame_checker.sv | 210 +++++++++++++++++++++
 tb/tb_rs_frame_checker.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared definitions for the RS receive path: field constants, FSM states,
// the alpha power table and GF(2^8) multiplication.
package rs_pkg;

    localparam int WORD_LENGTH = 8;
    localparam int N           = 15;
    localparam int K           = 11;
    localparam int NUM_PARITY  = N - K;
    localparam int CNT_W       = $clog2(N);
    localparam int PTR_W       = $clog2(K);

    localparam logic [WORD_LENGTH:0] PRIM_POLY = 9'h11D;

    typedef logic [WORD_LENGTH-1:0] symbol_t;

    typedef enum logic [2:0] {
        WAIT_SYMBOL,
        RECEIVE,
        CHECK,
        SEND_MESSAGE,
        ERROR
    } state_t;

    // alpha^0 .. alpha^15 under 0x11D; covers up to 16 parity symbols
    localparam symbol_t ALPHA_POW [0:15] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
        8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87, 8'h13, 8'h26
    };

    function automatic symbol_t gf_mult(input symbol_t a, input symbol_t b);
        symbol_t acc;
        symbol_t x;
        acc = '0;
        x   = a;
        for (int i = 0; i < WORD_LENGTH; i++) begin
            if (b[i]) begin
                acc = acc ^ x;
            end
            x = x[WORD_LENGTH-1] ? ((x << 1) ^ PRIM_POLY[WORD_LENGTH-1:0]) : (x << 1);
        end
        return acc;
    endfunction

endpackage

// File: rtl/rs_syndrome_calc.sv
// N-K syndrome accumulators in Horner form; S_j is evaluated at alpha^j,
// the same roots the encoder generator polynomial uses.
module rs_syndrome_calc
    import rs_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_load,
    input  logic                              i_enable,
    input  logic [WORD_LENGTH-1:0]            i_symbol,
    output logic [NUM_PARITY*WORD_LENGTH-1:0] o_syndromes
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PARITY; gi++) begin : g_syn
            logic [WORD_LENGTH-1:0] r_syn;

            // the start symbol seeds the accumulator so no separate clear cycle is needed
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_syn <= '0;
                end else if (i_load) begin
                    r_syn <= i_symbol;
                end else if (i_enable) begin
                    r_syn <= gf_mult(r_syn, ALPHA_POW[gi]) ^ i_symbol;
                end
            end

            assign o_syndromes[gi*WORD_LENGTH +: WORD_LENGTH] = r_syn;
        end
    endgenerate

endmodule

// File: rtl/rs_frame_checker.sv
// Receives framed RS codewords, flags corruption from the syndromes and
// replays the K message symbols downstream once the frame has been checked.
module rs_frame_checker
    import rs_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start_codeword,
    input  logic                   i_end_codeword,
    input  logic                   i_valid,
    input  logic [WORD_LENGTH-1:0] i_symbol,
    output logic                   o_in_ready,
    input  logic                   i_consume,
    output logic                   o_start_codeword,
    output logic                   o_end_codeword,
    output logic                   o_valid,
    output logic [WORD_LENGTH-1:0] o_symbol,
    output logic                   o_corrupted,
    output logic                   o_error
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_K    = CNT_W'(K);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(K - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        w_count_next;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [PTR_W-1:0]        w_rd_ptr_next;
    logic [PTR_W-1:0]        w_rd_ptr_inc;
    logic                    r_in_ready;
    logic                    w_in_ready_next;
    logic                    r_valid;
    logic                    w_valid_next;
    logic                    r_start;
    logic                    w_start_next;
    logic                    r_end;
    logic                    w_end_next;
    logic                    r_corrupted;
    logic                    w_corrupted_next;
    logic                    r_error;
    logic                    w_error_next;
    logic [WORD_LENGTH-1:0]  r_symbol;
    logic [WORD_LENGTH-1:0]  r_buffer [0:K-1];

    logic                    w_accept;
    logic                    w_syn_load;
    logic                    w_syn_enable;
    logic                    w_buf_we;
    logic [PTR_W-1:0]        w_buf_waddr;
    logic                    w_sym_load;
    logic [PTR_W-1:0]        w_sym_raddr;
    logic [NUM_PARITY*WORD_LENGTH-1:0] w_syndromes;

    assign w_accept     = i_valid && r_in_ready;
    assign w_rd_ptr_inc = r_rd_ptr + PTR_ONE;

    rs_syndrome_calc u_syndrome (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_syn_load),
        .i_enable    (w_syn_enable),
        .i_symbol    (i_symbol),
        .o_syndromes (w_syndromes)
    );

    always_comb begin
        w_state_next     = r_state;
        w_count_next     = r_count;
        w_rd_ptr_next    = r_rd_ptr;
        w_valid_next     = r_valid;
        w_start_next     = r_start;
        w_end_next       = r_end;
        w_corrupted_next = r_corrupted;
        w_syn_load       = 1'b0;
        w_syn_enable     = 1'b0;
        w_buf_we         = 1'b0;
        w_buf_waddr      = r_count[PTR_W-1:0];
        w_sym_load       = 1'b0;
        w_sym_raddr      = r_rd_ptr;

        case (r_state)
            WAIT_SYMBOL: begin
                if (w_accept) begin
                    if (i_start_codeword && !i_end_codeword) begin
                        w_state_next = RECEIVE;
                        w_count_next = CNT_ONE;
                        w_syn_load   = 1'b1;
                        w_buf_we     = 1'b1;
                        w_buf_waddr  = '0;
                    end else if (i_end_codeword) begin
                        w_state_next = ERROR;
                    end
                end
            end
            RECEIVE: begin
                if (w_accept) begin
                    w_syn_enable = 1'b1;
                    w_buf_we     = (r_count < CNT_K);
                    w_count_next = r_count + CNT_ONE;
                    // r_count is the index of the symbol being accepted
                    if (i_start_codeword) begin
                        w_state_next = ERROR;
                    end else if (i_end_codeword) begin
                        w_state_next = (r_count == CNT_LAST) ? CHECK : ERROR;
                    end else if (r_count == CNT_LAST) begin
                        w_state_next = ERROR;
                    end
                end
            end
            CHECK: begin
                w_corrupted_next = |w_syndromes;
                w_count_next     = '0;
                w_rd_ptr_next    = '0;
                w_state_next     = SEND_MESSAGE;
            end
            SEND_MESSAGE: begin
                if (!r_valid) begin
                    // first cycle here only primes the registered output
                    w_valid_next = 1'b1;
                    w_sym_load   = 1'b1;
                    w_start_next = (r_rd_ptr == '0);
                    w_end_next   = (r_rd_ptr == PTR_LAST);
                end else if (i_consume) begin
                    if (r_rd_ptr == PTR_LAST) begin
                        w_valid_next  = 1'b0;
                        w_start_next  = 1'b0;
                        w_end_next    = 1'b0;
                        w_rd_ptr_next = '0;
                        w_state_next  = WAIT_SYMBOL;
                    end else begin
                        w_rd_ptr_next = w_rd_ptr_inc;
                        w_sym_load    = 1'b1;
                        w_sym_raddr   = w_rd_ptr_inc;
                        w_start_next  = 1'b0;
                        w_end_next    = (w_rd_ptr_inc == PTR_LAST);
                    end
                end
            end
            ERROR: begin
                w_valid_next = 1'b0;
                w_start_next = 1'b0;
                w_end_next   = 1'b0;
            end
            default: begin
                w_state_next = WAIT_SYMBOL;
            end
        endcase

        w_in_ready_next = (w_state_next == WAIT_SYMBOL) || (w_state_next == RECEIVE);
        w_error_next    = r_error || (w_state_next == ERROR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WAIT_SYMBOL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_in_ready  <= 1'b1;
            r_valid     <= 1'b0;
            r_start     <= 1'b0;
            r_end       <= 1'b0;
            r_corrupted <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_count     <= w_count_next;
            r_rd_ptr    <= w_rd_ptr_next;
            r_in_ready  <= w_in_ready_next;
            r_valid     <= w_valid_next;
            r_start     <= w_start_next;
            r_end       <= w_end_next;
            r_corrupted <= w_corrupted_next;
            r_error     <= w_error_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buffer[w_buf_waddr] <= i_symbol;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_symbol <= '0;
        end else if (w_sym_load) begin
            r_symbol <= r_buffer[w_sym_raddr];
        end
    end

    assign o_in_ready       = r_in_ready;
    assign o_valid          = r_valid;
    assign o_start_codeword = r_start;
    assign o_end_codeword   = r_end;
    assign o_symbol         = r_symbol;
    assign o_corrupted      = r_corrupted;
    assign o_error          = r_error;

endmodule

// File: tb/tb_rs_frame_checker.sv
// Randomised bench for rs_frame_checker against a polynomial-evaluation model
// of the syndromes and a queue of expected output symbols.
module tb_rs_frame_checker;

    localparam int N  = 15;
    localparam int K  = 11;
    localparam int NP = N - K;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start_codeword;
    logic       i_end_codeword;
    logic       i_valid;
    logic [7:0] i_symbol;
    logic       o_in_ready;
    logic       i_consume;
    logic       o_start_codeword;
    logic       o_end_codeword;
    logic       o_valid;
    logic [7:0] o_symbol;
    logic       o_corrupted;
    logic       o_error;

    rs_frame_checker dut (
        .clk              (clk),
        .rst              (rst),
        .i_start_codeword (i_start_codeword),
        .i_end_codeword   (i_end_codeword),
        .i_valid          (i_valid),
        .i_symbol         (i_symbol),
        .o_in_ready       (o_in_ready),
        .i_consume        (i_consume),
        .o_start_codeword (o_start_codeword),
        .o_end_codeword   (o_end_codeword),
        .o_valid          (o_valid),
        .o_symbol         (o_symbol),
        .o_corrupted      (o_corrupted),
        .o_error          (o_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sym;
        logic       st;
        logic       en;
        logic       corr;
        int         idx;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] cw  [0:N-1];
    logic [7:0] msg [0:K-1];
    int         exp_tab [0:509];
    int         log_tab [0:255];
    int         gen [0:NP];
    longint     last_acc_time = 0;
    bit         lat_checked = 1'b1;
    bit         exp_error = 1'b0;
    int         cons_mode = 0;
    int         hold_cnt = 0;
    int         stall_seen = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_tab[log_tab[a] + log_tab[b]];
    endfunction

    function automatic void build_tables();
        int x;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            exp_tab[i] = x;
            log_tab[x] = i;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11D;
        end
        for (int i = 255; i < 510; i++) exp_tab[i] = exp_tab[i-255];
        log_tab[0] = 0;
        for (int k = 0; k <= NP; k++) gen[k] = 0;
        gen[0] = 1;
        for (int j = 0; j < NP; j++) begin
            for (int k = NP; k >= 1; k--) gen[k] = gen[k-1] ^ gmul(gen[k], exp_tab[j]);
            gen[0] = gmul(gen[0], exp_tab[j]);
        end
    endfunction

    // Syndrome j is the received polynomial evaluated at alpha^j
    function automatic bit model_corrupted();
        for (int j = 0; j < NP; j++) begin
            int s;
            s = 0;
            for (int i = 0; i < N; i++) s = s ^ gmul(int'(cw[i]), exp_tab[(j * (N - 1 - i)) % 255]);
            if (s != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Systematic encoding: parity = msg(x)*x^(N-K) mod g(x)
    function automatic void encode();
        int rem [0:NP-1];
        int fb;
        for (int k = 0; k < NP; k++) rem[k] = 0;
        for (int i = 0; i < K; i++) begin
            cw[i] = msg[i];
            fb = int'(msg[i]) ^ rem[NP-1];
            for (int k = NP - 1; k >= 1; k--) rem[k] = rem[k-1] ^ gmul(fb, gen[k]);
            rem[0] = gmul(fb, gen[0]);
        end
        for (int k = 0; k < NP; k++) cw[K+k] = 8'(rem[NP-1-k]);
    endfunction

    task automatic send_sym(input bit st, input bit en, input logic [7:0] s, output bit ok);
        bit acc;
        i_valid = 1'b1;
        i_start_codeword = st;
        i_end_codeword = en;
        i_symbol = s;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            acc = o_in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) last_acc_time = longint'($time) - 1;
        else chk("accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic send_frame(input int gap_pct, input int junk, input string tag);
        bit ok;
        bit corr;
        corr = model_corrupted();
        for (int j = 0; j < junk; j++) send_sym(1'b0, 1'b0, 8'($urandom_range(255)), ok);
        for (int i = 0; i < N; i++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                i_valid = 1'b0;
                i_start_codeword = 1'($urandom_range(1));
                i_end_codeword = 1'($urandom_range(1));
                i_symbol = 8'($urandom_range(255));
                @(posedge clk);
                #1;
            end
            send_sym(i == 0, i == N - 1, cw[i], ok);
            if (i == 0) chk("no_overlap", 64'(exp_q.size()), 64'd0);
        end
        i_valid = 1'b0;
        i_start_codeword = 1'b0;
        i_end_codeword = 1'b0;
        for (int i = 0; i < K; i++) begin
            exp_t e;
            e.sym = cw[i];
            e.st = (i == 0);
            e.en = (i == K - 1);
            e.corr = corr;
            e.idx = i;
            exp_q.push_back(e);
        end
        lat_checked = 1'b0;
        $display("tb: frame %s sent, model corrupted=%0b", tag, corr);
    endtask

    task automatic drain();
        for (int c = 0; c < 400; c++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_vals();
        @(negedge clk);
        chk("rst_in_ready", 64'(o_in_ready), 64'd1);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_start", 64'(o_start_codeword), 64'd0);
        chk("rst_end", 64'(o_end_codeword), 64'd0);
        chk("rst_corrupted", 64'(o_corrupted), 64'd0);
        chk("rst_error", 64'(o_error), 64'd0);
        chk("rst_symbol", 64'(o_symbol), 64'd0);
    endtask

    task automatic err_test(input int kind);
        bit ok;
        for (int i = 0; i < K; i++) msg[i] = 8'($urandom_range(255));
        encode();
        case (kind)
            0: begin
                for (int i = 0; i < 9; i++) send_sym(i == 0, 1'b0, cw[i], ok);
                send_sym(1'b0, 1'b1, cw[9], ok);
            end
            1: begin
                for (int i = 0; i < 5; i++) send_sym(i == 0, 1'b0, cw[i], ok);
                send_sym(1'b1, 1'b0, cw[5], ok);
            end
            2: send_sym(1'b0, 1'b1, cw[0], ok);
            default: send_sym(1'b1, 1'b1, cw[0], ok);
        endcase
        exp_error = 1'b1;
        i_start_codeword = 1'b1;
        i_end_codeword = 1'b0;
        $display("tb: framing error case %0d injected", kind);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("err_sticky", 64'(o_error), 64'd1);
            chk("err_in_ready", 64'(o_in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        i_valid = 1'b0;
        exp_error = 1'b0;
        @(negedge clk);
        chk("err_cleared", 64'(o_error), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Consumer: 0 = always take, 1 = random, 2 = stall three cycles on the 4th symbol
    initial begin
        i_consume = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (cons_mode)
                0: i_consume = 1'b1;
                1: i_consume = ($urandom_range(3) != 0);
                default: begin
                    if (o_valid && exp_q.size() > 0 && exp_q[0].idx == 3 && hold_cnt < 3) begin
                        i_consume = 1'b0;
                        hold_cnt++;
                    end else begin
                        i_consume = 1'b1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("o_error", 64'(o_error), 64'(exp_error));
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 64'(o_valid), 64'd0);
                end else begin
                    chk("out_symbol", 64'(o_symbol), 64'(exp_q[0].sym));
                    chk("out_start", 64'(o_start_codeword), 64'(exp_q[0].st));
                    chk("out_end", 64'(o_end_codeword), 64'(exp_q[0].en));
                    chk("out_corrupted", 64'(o_corrupted), 64'(exp_q[0].corr));
                    chk("in_ready_while_out", 64'(o_in_ready), 64'd0);
                    if (!lat_checked && exp_q[0].idx == 0) begin
                        lat_checked = 1'b1;
                        chk("latency_time", 64'(longint'($time) - last_acc_time), 64'd25);
                    end
                    if (cons_mode == 2 && !i_consume && exp_q[0].idx == 3) stall_seen++;
                    if (i_consume) begin
                        $display("tb: out idx=%0d sym=%02h start=%0b end=%0b corrupted=%0b",
                                 exp_q[0].idx, o_symbol, o_start_codeword, o_end_codeword, o_corrupted);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst = 1'b1;
        i_valid = 1'b0;
        i_start_codeword = 1'b0;
        i_end_codeword = 1'b0;
        i_symbol = 8'h00;
        build_tables();

        // hand-expanded (x+1)(x+2)(x+4)(x+8) over 0x11D
        chk("gen_x4", 64'(gen[4]), 64'h01);
        chk("gen_x3", 64'(gen[3]), 64'h0F);
        chk("gen_x2", 64'(gen[2]), 64'h36);
        chk("gen_x1", 64'(gen[1]), 64'h78);
        chk("gen_x0", 64'(gen[0]), 64'h40);

        repeat (3) @(posedge clk);
        check_reset_vals();
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < K; i++) msg[i] = 8'h00;
        encode();
        chk("model_zero_clean", 64'(model_corrupted()), 64'd0);
        send_frame(0, 0, "all_zero");
        drain();

        for (int i = 0; i < K; i++) msg[i] = 8'(i + 1);
        encode();
        chk("model_enc_clean", 64'(model_corrupted()), 64'd0);
        send_frame(0, 0, "msg_1_to_11");
        drain();

        cw[4] = cw[4] ^ 8'h01;
        chk("corrupt_sym_lit", 64'(cw[4]), 64'h04);
        chk("model_enc_dirty", 64'(model_corrupted()), 64'd1);
        send_frame(0, 0, "msg_sym5_flipped");
        drain();

        cw[4] = cw[4] ^ 8'h01;
        cons_mode = 2;
        hold_cnt = 0;
        stall_seen = 0;
        send_frame(0, 0, "backpressure");
        send_frame(0, 0, "after_backpressure");
        drain();
        chk("stall_cycles", 64'(stall_seen), 64'd3);

        cons_mode = 1;
        for (int f = 0; f < 12; f++) begin
            int nerr;
            for (int i = 0; i < K; i++) msg[i] = 8'($urandom_range(255));
            encode();
            nerr = $urandom_range(2);
            for (int e = 0; e < nerr; e++) begin
                int pos;
                pos = $urandom_range(N - 1);
                cw[pos] = cw[pos] ^ 8'($urandom_range(1, 255));
            end
            send_frame(25, $urandom_range(2), "random");
        end
        drain();

        cons_mode = 0;
        for (int i = 0; i < K; i++) msg[i] = 8'($urandom_range(255));
        encode();
        for (int i = 0; i < 7; i++) send_sym(i == 0, 1'b0, cw[i], ok);
        rst = 1'b1;
        i_valid = 1'b0;
        $display("tb: rst asserted after 7 symbols");
        check_reset_vals();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(0, 0, "after_midframe_rst");
        drain();

        for (int k = 0; k < 4; k++) err_test(k);

        for (int i = 0; i < K; i++) msg[i] = 8'(8'hA0 + i);
        encode();
        send_frame(0, 0, "post_error_clean");
        drain();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
